// File: rtl/mips_boot_pkg.sv
// Shared definitions for the MIPS boot loader: frame header codes and FSM states.
package mips_boot_pkg;

  typedef enum logic [2:0] {
    S_HDR,
    S_CNT,
    S_BYTE,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [7:0] TGT_IMEM = 8'h00;
  localparam logic [7:0] TGT_REGF = 8'h01;
  localparam logic [7:0] TGT_DMEM = 8'h02;
  localparam logic [7:0] HDR_END  = 8'hFF;

  function automatic logic is_target(input logic [7:0] hdr);
    return (hdr == TGT_IMEM) || (hdr == TGT_REGF) || (hdr == TGT_DMEM);
  endfunction

endpackage

// File: rtl/word_packer.sv
// Big-endian byte-to-word assembler: keeps the first three bytes of a word and
// presents them joined with the currently offered byte as the complete word.
module word_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [1:0]  idx_o
);

  logic [23:0] hold_q;
  logic [1:0]  idx_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      hold_q <= '0;
      idx_q  <= '0;
    end else if (shift_i) begin
      hold_q <= {hold_q[15:0], byte_i};
      idx_q  <= idx_q + 2'd1;
    end
  end

  // Fourth byte is used in the same cycle it transfers, so it is never stored.
  assign word_o = {hold_q, byte_i};
  assign idx_o  = idx_q;

endmodule

// File: rtl/boot_loader.sv
// Streams framed bytes into CPU instruction/register/data memories, then
// releases the CPU from reset on the end header or holds it on a bad header.
module boot_loader
  import mips_boot_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [1:0]        wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_reset_n,
  output logic              done,
  output logic              error
);

  state_e             state_q;
  logic [1:0]         tgt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               wr_en_q;
  logic [1:0]         wr_sel_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [31:0]        wr_data_q;
  logic               done_q;
  logic               error_q;
  logic               cpu_rst_n_q;

  logic               xfer;
  logic [CNT_W-1:0]   cnt_in;
  logic [31:0]        pk_word;
  logic [1:0]         pk_idx;

  assign in_ready = (state_q == S_HDR) || (state_q == S_CNT) || (state_q == S_BYTE);
  assign xfer     = in_valid && in_ready;
  assign cnt_in   = CNT_W'(in_data);

  word_packer u_packer (
    .clk_i   (clock),
    .rst_i   (reset),
    .clear_i (xfer && (state_q == S_CNT)),
    .shift_i (xfer && (state_q == S_BYTE)),
    .byte_i  (in_data),
    .word_o  (pk_word),
    .idx_o   (pk_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_HDR;
      tgt_q       <= '0;
      cnt_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_sel_q    <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_HDR: if (xfer) begin
          if (is_target(in_data)) begin
            tgt_q   <= in_data[1:0];
            state_q <= S_CNT;
          end else if (in_data == HDR_END) begin
            done_q      <= 1'b1;
            cpu_rst_n_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            error_q <= 1'b1;
            state_q <= S_ERR;
          end
        end
        S_CNT: if (xfer) begin
          cnt_q     <= cnt_in;
          wr_addr_q <= '0;
          state_q   <= (cnt_in == '0) ? S_HDR : S_BYTE;
        end
        S_BYTE: if (xfer && (pk_idx == 2'd3)) begin
          wr_en_q   <= 1'b1;
          wr_sel_q  <= tgt_q;
          wr_data_q <= pk_word;
          state_q   <= S_WRITE;
        end
        S_WRITE: begin
          wr_en_q   <= 1'b0;
          wr_addr_q <= wr_addr_q + ADDR_W'(1);
          cnt_q     <= cnt_q - CNT_W'(1);
          state_q   <= (cnt_q == CNT_W'(1)) ? S_HDR : S_BYTE;
        end
        S_DONE, S_ERR: ;
        default: state_q <= S_HDR;
      endcase
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_sel      = wr_sel_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign done        = done_q;
  assign error       = error_q;
  assign cpu_reset_n = cpu_rst_n_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed scoreboard bench for boot_loader (address width narrowed to 2 to reach wrap).
module tb_boot_loader;

  localparam int AW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          wr_en;
  logic [1:0]    wr_sel;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_reset_n;
  logic          done;
  logic          error;

  typedef struct packed {
    logic [1:0]    sel;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  writes_seen = 0;
  int  nr_cycles = 0;
  bit  count_nr = 1'b0;
  int  max_gap = 0;

  boot_loader #(.ADDR_W(AW), .CNT_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .cpu_reset_n (cpu_reset_n),
    .done        (done),
    .error       (error)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest scoreboard entry.
  wr_t e;
  always @(negedge clock) begin
    if (count_nr && !done && !error && in_ready === 1'b0) nr_cycles++;
    if (wr_en === 1'b1) begin
      writes_seen++;
      check("write_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("wr_sel", 64'(wr_sel), 64'(e.sel));
        check("wr_addr", 64'(wr_addr), 64'(e.addr));
        check("wr_data", 64'(wr_data), 64'(e.data));
        check("in_ready_on_write", 64'(in_ready), 64'd0);
        check("cpu_reset_n_on_write", 64'(cpu_reset_n), 64'd0);
      end
    end
  end

  task automatic push(input logic [1:0] s, input logic [AW-1:0] a, input logic [31:0] d);
    wr_t t;
    t.sel = s; t.addr = a; t.data = d;
    sb.push_back(t);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_cpu_reset_n", 64'(cpu_reset_n), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_wr_sel", 64'(wr_sel), 64'd0);
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    int gap;
    gap = (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
    repeat (gap) @(negedge clock);
    in_valid = 1'b1;
    in_data = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) check("byte_accept_bound", 64'(n), 64'd0);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send(w[31:24]); send(w[23:16]); send(w[15:8]); send(w[7:0]);
  endtask

  task automatic expect_done(input string tag, input int w0, input int nwr);
    @(negedge clock);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_cpu_reset_n"}, 64'(cpu_reset_n), 64'd1);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_drained"}, 64'(sb.size()), 64'd0);
    check({tag, "_write_count"}, 64'(writes_seen - w0), 64'(nwr));
  endtask

  initial begin
    int w0;

    // Basic two-word instruction frame
    do_reset();
    w0 = writes_seen;
    push(2'd0, 2'd0, 32'h12345678);
    push(2'd0, 2'd1, 32'h9ABCDEF0);
    send(8'h00); send(8'h02);
    send_word(32'h12345678);
    send_word(32'h9ABCDEF0);
    @(negedge clock);
    check("t1_cpu_held_before_end", 64'(cpu_reset_n), 64'd0);
    send(8'hFF);
    expect_done("t1", w0, 2);
    in_valid = 1'b1;
    in_data = 8'h00;
    repeat (3) @(negedge clock);
    check("t1_done_held", 64'(done), 64'd1);
    check("t1_in_ready_held", 64'(in_ready), 64'd0);
    in_valid = 1'b0;

    // Register file and data memory frames, each starting at address 0
    do_reset();
    w0 = writes_seen;
    push(2'd1, 2'd0, 32'h00000005);
    push(2'd2, 2'd0, 32'h0000000A);
    send(8'h01); send(8'h01); send_word(32'h00000005);
    send(8'h02); send(8'h01); send_word(32'h0000000A);
    send(8'hFF);
    expect_done("t2", w0, 2);

    // Invalid header locks into error with the CPU held
    do_reset();
    w0 = writes_seen;
    send(8'h07);
    @(negedge clock);
    check("t3_error", 64'(error), 64'd1);
    check("t3_in_ready", 64'(in_ready), 64'd0);
    check("t3_done", 64'(done), 64'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = (i == 0) ? 8'hFF : 8'(i);
      @(negedge clock);
      check("t3_cpu_reset_n", 64'(cpu_reset_n), 64'd0);
      check("t3_error_held", 64'(error), 64'd1);
    end
    in_valid = 1'b0;
    check("t3_no_writes", 64'(writes_seen - w0), 64'd0);

    // Zero-count frame writes nothing
    do_reset();
    w0 = writes_seen;
    send(8'h00); send(8'h00); send(8'hFF);
    expect_done("t4", w0, 0);

    // Reset mid-word discards the partial word
    do_reset();
    w0 = writes_seen;
    send(8'h00); send(8'h01); send(8'hAA); send(8'hBB);
    do_reset();
    send(8'hFF);
    expect_done("t5", w0, 0);

    // Count beyond the address space wraps; next frame restarts at 0
    do_reset();
    w0 = writes_seen;
    for (int i = 0; i < 5; i++) push(2'd2, AW'(i), 32'hC0DE0000 + 32'(i));
    push(2'd2, 2'd0, 32'hFEEDBEEF);
    send(8'h02); send(8'h05);
    for (int i = 0; i < 5; i++) send_word(32'hC0DE0000 + 32'(i));
    send(8'h02); send(8'h01); send_word(32'hFEEDBEEF);
    send(8'hFF);
    expect_done("t6", w0, 6);

    // Random input gaps across the basic stream
    do_reset();
    w0 = writes_seen;
    nr_cycles = 0;
    count_nr = 1'b1;
    max_gap = 3;
    push(2'd0, 2'd0, 32'h12345678);
    push(2'd0, 2'd1, 32'h9ABCDEF0);
    send(8'h00); send(8'h02);
    send_word(32'h12345678);
    send_word(32'h9ABCDEF0);
    send(8'hFF);
    expect_done("t7", w0, 2);
    count_nr = 1'b0;
    max_gap = 0;
    check("t7_not_ready_cycles", 64'(nr_cycles), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter ADDR_W, default 8, sets the word-address width of every load target.
REQ-002 Parameter CNT_W, default 8, sets the width of the per-frame word-count field.
REQ-003 Port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: a byte is offered on in_data.
REQ-006 Port in_data, input, 8: the offered byte.
REQ-007 Port in_ready, output, 1: the loader accepts a byte this cycle; transfer occurs when in_valid and in_ready are both 1.
REQ-008 Port wr_en, output, 1: one-cycle write strobe to the selected memory.
REQ-009 Port wr_sel, output, 2: write target (0 = instruction memory, 1 = register file, 2 = data memory).
REQ-010 Port wr_addr, output, ADDR_W: word address of the write.
REQ-011 Port wr_data, output, 32: word to write.
REQ-012 Port cpu_reset_n, output, 1: active-low reset to the MIPS CPU.
REQ-013 Port done, output, 1: load completed; CPU released.
REQ-014 Port error, output, 1: invalid header received; load aborted.

Function
REQ-015 Input stream is a sequence of frames; each frame is HDR byte, CNT byte, then CNT words of 4 bytes each, most significant byte first.
REQ-016 HDR 0x00/0x01/0x02 selects the target; HDR 0xFF ends the load; any other HDR value is invalid.
REQ-017 States: S_HDR, S_CNT, S_BYTE, S_WRITE, S_DONE, S_ERR.
REQ-018 S_HDR: in_ready=1; on transfer go to S_CNT for valid target, S_DONE for 0xFF, S_ERR otherwise.
REQ-019 S_CNT: in_ready=1; on transfer latch count and clear wr_addr to 0; count 0 returns to S_HDR with no write; otherwise go to S_BYTE with byte index 0.
REQ-020 S_BYTE: in_ready=1; each transfer shifts in_data into the low byte of the assembly register; the 4th transfer goes to S_WRITE.
REQ-021 S_WRITE: lasts exactly one cycle with in_ready=0, wr_en=1, wr_sel=latched target, wr_addr=current address, wr_data=assembled word.
REQ-022 After S_WRITE, wr_addr increments by 1 (modulo 2^ADDR_W); go to S_BYTE if words remain, else S_HDR.
REQ-023 Latency: wr_en asserts the cycle after the 4th byte of a word transfers.
REQ-024 in_valid low in any state holds all state; no timeout.
REQ-025 A count exceeding 2^ADDR_W wraps the address to 0 and overwrites; no error is raised.
REQ-026 Multiple frames to the same target are legal; each restarts at address 0.
REQ-027 S_DONE: in_ready=0, done=1, cpu_reset_n=1, held until reset.
REQ-028 S_ERR: in_ready=0, error=1, cpu_reset_n=0, held until reset.
REQ-029 cpu_reset_n=0 in every state except S_DONE; it rises the cycle after the 0xFF header transfers.
REQ-030 wr_en=0 in every state except S_WRITE; wr_sel/wr_addr/wr_data hold between writes.

Reset
REQ-031 reset=1 at a clock edge forces S_HDR, byte index 0, wr_addr 0, wr_data 0, wr_sel 0, wr_en 0, done 0, error 0, cpu_reset_n 0; in_ready=1 from the next cycle.
REQ-032 reset mid-frame discards the partial word and performs no write; the next accepted byte is treated as HDR.
REQ-033 reset has priority over any simultaneous transfer.

Structure
REQ-034 Target codes (0x00, 0x01, 0x02), end code 0xFF and the state enumeration reside in shared package mips_boot_pkg.
REQ-035 Byte-to-word assembly is a sub-module word_packer (shift register plus 2-bit byte counter, with clear and shift inputs).

Verification
REQ-036 Frame 00,02,12,34,56,78,9A,BC,DE,F0 then FF -> writes (sel0,a0,0x12345678), (sel0,a1,0x9ABCDEF0); done=1 and cpu_reset_n=1 the cycle after FF.
REQ-037 Frames 01,01,00000005 then 02,01,0000000A then FF -> reg[0]=5, data[0]=0xA; each write at address 0.
REQ-038 HDR 0x07 -> error=1, in_ready=0, no writes, cpu_reset_n stays 0 through 20 further cycles of in_valid=1.
REQ-039 Frame 00,00 then FF -> no wr_en pulse; done=1.
REQ-040 Frame 00,01,AA,BB (2 bytes), then reset, then FF -> no write; done=1.
REQ-041 Random in_valid gaps across the REQ-036 stream -> identical writes; in_ready=0 exactly on the two S_WRITE cycles.
